// File: rtl/renkon_accum_ctrl_if.sv
// Handshake, buffer and accumulator control bundle between the stream feeder,
// the renkon accumulator controller and the accumulator/partial-sum buffer pair.
interface renkon_accum_ctrl_if #(
  parameter int CHWIDTH = 10,
  parameter int PXWIDTH = 12
);
  logic               start;
  logic [CHWIDTH-1:0] n_in;
  logic [PXWIDTH-1:0] n_pix;
  logic               busy;
  logic               done;
  logic               in_valid;
  logic               in_ready;
  logic               mem_rd_en;
  logic [PXWIDTH-1:0] mem_raddr;
  logic               mem_we;
  logic [PXWIDTH-1:0] mem_waddr;
  logic               acc_reset;
  logic               acc_out_en;
  logic               out_valid;
  logic               out_last;

  modport master (
    output start, n_in, n_pix, in_valid,
    input  busy, done, in_ready, mem_rd_en, mem_raddr, mem_we, mem_waddr,
           acc_reset, acc_out_en, out_valid, out_last
  );

  modport slave (
    input  start, n_in, n_pix, in_valid,
    output busy, done, in_ready, mem_rd_en, mem_raddr, mem_we, mem_waddr,
           acc_reset, acc_out_en, out_valid, out_last
  );
endinterface

// File: rtl/renkon_accum_ctrl.sv
// Sequencer for one output map: n_in accumulate passes of n_pix pixels through
// the partial-sum buffer, then a flush pass driving the accumulator output latch.
module renkon_accum_ctrl #(
  parameter int CHWIDTH = 10,
  parameter int PXWIDTH = 12
) (
  input logic                clk,
  input logic                xrst,
  renkon_accum_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [CHWIDTH-1:0] CH_ONE = CHWIDTH'(1);
  localparam logic [PXWIDTH-1:0] PX_ONE = PXWIDTH'(1);

  state_t state, next_state;

  logic [CHWIDTH-1:0] n_in_q, ch, ch_max;
  logic [PXWIDTH-1:0] n_pix_q, px, px_max;
  logic               drain_cnt;
  logic               bubble_q;
  logic               px_last, ch_last;

  logic               in_ready_c, accept_c, rd_en_c;
  logic [PXWIDTH-1:0] raddr_c;

  logic               busy_q, done_q;
  logic               mem_we_q, acc_reset_q;
  logic [PXWIDTH-1:0] mem_waddr_q;
  logic               acc_out_en_q, last_s1_q;
  logic               out_valid_q, out_last_q;

  assign ch_max  = n_in_q - CH_ONE;
  assign px_max  = n_pix_q - PX_ONE;
  assign px_last = (px == px_max);
  assign ch_last = (ch == ch_max);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if ((bus.n_in == '0) || (bus.n_pix == '0)) next_state = S_DONE;
          else                                       next_state = S_ACCUM;
        end
      end
      S_ACCUM: if (accept_c && ch_last && px_last) next_state = S_FLUSH;
      S_FLUSH: if (px_last)   next_state = S_DRAIN;
      S_DRAIN: if (drain_cnt) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // With a single pixel per pass, the bubble after each accept keeps the next
  // read of address 0 from overlapping the write still in flight.
  always_comb begin
    in_ready_c = (state == S_ACCUM) && !bubble_q;
    accept_c   = in_ready_c && bus.in_valid;
    rd_en_c    = accept_c || (state == S_FLUSH);
    raddr_c    = rd_en_c ? px : '0;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_rd_en = rd_en_c;
  assign bus.mem_raddr = raddr_c;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      n_in_q    <= '0;
      n_pix_q   <= '0;
      ch        <= '0;
      px        <= '0;
      drain_cnt <= 1'b0;
      bubble_q  <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        n_in_q  <= bus.n_in;
        n_pix_q <= bus.n_pix;
        ch      <= '0;
        px      <= '0;
      end else if (accept_c) begin
        if (px_last) begin
          px <= '0;
          ch <= ch + CH_ONE;
        end else begin
          px <= px + PX_ONE;
        end
      end else if (state == S_FLUSH) begin
        px <= px_last ? '0 : px + PX_ONE;
      end
      drain_cnt <= (state == S_DRAIN) && !drain_cnt;
      bubble_q  <= accept_c && (n_pix_q == PX_ONE);
    end
  end

  // Write-back and flush pipelines trail the read by one and two cycles,
  // matching the buffer read latency and the accumulator output latch.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= '0;
      acc_reset_q  <= 1'b0;
      acc_out_en_q <= 1'b0;
      last_s1_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      busy_q       <= (next_state != S_IDLE);
      done_q       <= (state == S_DONE);
      mem_we_q     <= accept_c;
      mem_waddr_q  <= accept_c ? px : '0;
      acc_reset_q  <= accept_c && (ch == '0);
      acc_out_en_q <= (state == S_FLUSH);
      last_s1_q    <= (state == S_FLUSH) && px_last;
      out_valid_q  <= acc_out_en_q;
      out_last_q   <= last_s1_q;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_waddr  = mem_waddr_q;
  assign bus.acc_reset  = acc_reset_q;
  assign bus.acc_out_en = acc_out_en_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;

endmodule

// File: tb/tb_renkon_accum_ctrl.sv
// Scoreboard bench for renkon_accum_ctrl: a behavioural buffer/accumulator model
// driven by the DUT's controls produces per-pixel sums checked against hand totals.
module tb_renkon_accum_ctrl;

  localparam int CHW = 10;
  localparam int PXW = 12;

  logic clk = 1'b0;
  logic xrst;
  always #5 clk = ~clk;

  renkon_accum_ctrl_if #(.CHWIDTH(CHW), .PXWIDTH(PXW)) bus ();

  renkon_accum_ctrl #(.CHWIDTH(CHW), .PXWIDTH(PXW)) dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus)
  );

  typedef struct {
    int addr;
    bit rst;
  } wr_t;

  typedef struct {
    int sum;
    bit last;
  } out_t;

  wr_t  exp_wr[$];
  out_t exp_out[$];
  int   exp_done;

  int n_checks = 0;
  int n_errors = 0;

  int cur_pix;
  int npix_cfg;
  int mem [16];
  int rd_data_q, pix_q, out_latch;
  bit acc_prev;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int pix_val(input int ch, input int px);
    return ch * 16 + px + 1;
  endfunction

  function automatic int any_out();
    return int'(bus.busy | bus.done | bus.in_ready | bus.mem_rd_en | (|bus.mem_raddr) |
                bus.mem_we | (|bus.mem_waddr) | bus.acc_reset | bus.acc_out_en |
                bus.out_valid | bus.out_last);
  endfunction

  // Monitor: buffer with write-first read, accumulator, output latch, scoreboard pops.
  always @(negedge clk) begin
    if (!xrst) begin
      acc_prev = 1'b0;
    end else begin
      bit   acc_now;
      wr_t  w;
      out_t o;
      if (bus.out_valid) begin
        check("out_pending", int'(exp_out.size() != 0), 1);
        if (exp_out.size() != 0) begin
          o = exp_out.pop_front();
          check("out_sum", out_latch, o.sum);
          check("out_last", int'(bus.out_last), int'(o.last));
        end
      end
      if (bus.acc_out_en) out_latch = rd_data_q;
      if (bus.mem_we || acc_prev) check("we_after_accept", int'(bus.mem_we), int'(acc_prev));
      if (bus.mem_we) begin
        check("wr_pending", int'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) begin
          w = exp_wr.pop_front();
          check("waddr", int'(bus.mem_waddr), w.addr);
          check("acc_reset", int'(bus.acc_reset), int'(w.rst));
        end
        mem[int'(bus.mem_waddr[3:0])] = (bus.acc_reset ? 0 : rd_data_q) + pix_q;
      end
      if (npix_cfg == 1 && acc_prev) check("raw_bubble", int'(bus.in_ready), 0);
      if (bus.in_ready && !bus.in_valid) check("rd_in_gap", int'(bus.mem_rd_en), 0);
      acc_now = bus.in_valid && bus.in_ready;
      if (acc_now) check("rd_on_accept", int'(bus.mem_rd_en), 1);
      if (bus.mem_rd_en) rd_data_q = mem[int'(bus.mem_raddr[3:0])];
      if (acc_now) pix_q = cur_pix;
      acc_prev = acc_now;
      if (bus.done) begin
        check("done_expected", exp_done, 1);
        if (exp_done > 0) exp_done--;
      end
    end
  end

  task automatic push_map(input int nin, input int npix, input int sums[4]);
    wr_t  w;
    out_t o;
    for (int c = 0; c < nin; c++) begin
      for (int p = 0; p < npix; p++) begin
        w.addr = p;
        w.rst  = (c == 0);
        exp_wr.push_back(w);
      end
    end
    for (int p = 0; p < npix; p++) begin
      o.sum  = sums[p];
      o.last = (p == npix - 1);
      exp_out.push_back(o);
    end
    exp_done++;
  endtask

  // Entered and left just after a rising edge; garbage on n_in/n_pix afterwards
  // must not disturb the running map.
  task automatic start_map(input int nin, input int npix);
    bus.n_in   = CHW'(nin);
    bus.n_pix  = PXW'(npix);
    bus.start  = 1'b1;
    npix_cfg   = npix;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.n_in   = CHW'(7);
    bus.n_pix  = PXW'(5);
    check("busy_after_start", int'(bus.busy), 1);
  endtask

  task automatic feed(input int nin, input int npix, input bit toggle,
                      input int glitch_cyc, output int cycles);
    int got = 0;
    int cyc = 0;
    int fch = 0;
    int fpx = 0;
    while (got < nin * npix && cyc < 400) begin
      bus.in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      cur_pix      = pix_val(fch, fpx);
      if (cyc == glitch_cyc) bus.start = 1'b1;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        got++;
        if (fpx == npix - 1) begin
          fpx = 0;
          fch++;
        end else begin
          fpx++;
        end
      end
      cyc++;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;
    check("all_accepted", got, nin * npix);
    cycles = cyc;
  endtask

  task automatic wait_done();
    int k    = 0;
    bit seen = 1'b0;
    while (k < 60 && !seen) begin
      @(negedge clk);
      seen = bus.done;
      k++;
    end
    check("done_seen", int'(seen), 1);
    @(posedge clk); #1;
    check("wr_queue_drained", exp_wr.size(), 0);
    check("out_queue_drained", exp_out.size(), 0);
  endtask

  task automatic zero_map(input int nin, input int npix);
    exp_done++;
    start_map(nin, npix);
    @(negedge clk);
    check("zero_done_early", int'(bus.done), 0);
    @(negedge clk);
    check("zero_done", int'(bus.done), 1);
    check("zero_busy_low", int'(bus.busy), 0);
    @(posedge clk); #1;
    check("zero_no_writes", exp_wr.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int k;
    xrst         = 1'b0;
    bus.start    = 1'b0;
    bus.n_in     = '0;
    bus.n_pix    = '0;
    bus.in_valid = 1'b0;
    cur_pix      = 0;
    npix_cfg     = 0;
    exp_done     = 0;
    rd_data_q    = 0;
    pix_q        = 0;
    out_latch    = 0;
    acc_prev     = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", any_out(), 0);
    @(posedge clk); #1;
    xrst = 1'b1;

    // 3 channels x 4 pixels, continuous valid, stray start mid-ACCUM.
    // Sums per pixel: (1+17+33, 2+18+34, 3+19+35, 4+20+36).
    push_map(3, 4, '{51, 54, 57, 60});
    start_map(3, 4);
    feed(3, 4, 1'b0, 5, cyc);
    check("cont_cycles", cyc, 12);
    wait_done();

    // Same map with in_valid toggling 1010...
    push_map(3, 4, '{51, 54, 57, 60});
    start_map(3, 4);
    feed(3, 4, 1'b1, -1, cyc);
    check("toggle_cycles", cyc, 23);
    wait_done();

    // Single pixel, 4 channels: bubble after every accept. Sum 1+17+33+49.
    push_map(4, 1, '{100, 0, 0, 0});
    start_map(4, 1);
    feed(4, 1, 1'b0, -1, cyc);
    check("npix1_cycles", cyc, 7);
    wait_done();

    zero_map(0, 4);
    zero_map(3, 0);

    // Abort during FLUSH, then a clean map. Sums (1+17, 2+18, 3+19, 4+20).
    push_map(2, 4, '{18, 20, 22, 24});
    start_map(2, 4);
    feed(2, 4, 1'b0, -1, cyc);
    k = 0;
    @(negedge clk);
    while (k < 20 && !bus.acc_out_en) begin
      @(negedge clk);
      k++;
    end
    check("flush_reached", int'(bus.acc_out_en), 1);
    xrst = 1'b0;
    #1;
    check("async_reset_outputs", any_out(), 0);
    exp_wr.delete();
    exp_out.delete();
    exp_done = 0;
    @(posedge clk); #1;
    check("reset_edge_outputs", any_out(), 0);
    xrst = 1'b1;
    @(posedge clk); #1;

    push_map(2, 3, '{18, 20, 22, 0});
    start_map(2, 3);
    feed(2, 3, 1'b0, -1, cyc);
    check("post_reset_cycles", cyc, 6);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
